dma_priority: RTL



---
 rtl/dma_priority_if.sv | 35 +++
 rtl/dma_priority.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dma_priority_if.sv
// Channel-request bus between the DMA register file / peripherals / CPU hold
// logic and the dma_priority arbiter. The arbiter uses the slave modport; the
// surrounding environment (register block, CPU hold logic, timing control)
// uses the master modport.
interface dma_priority_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] DREQ;
  logic              DREQ_SENSE_LOW;
  logic              DACK_SENSE_HIGH;
  logic              ROT_PRIO;
  logic [NUM_CH-1:0] CH_MASK;
  logic [NUM_CH-1:0] SW_REQ;
  logic              HLDA;
  logic              SVC_DONE;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [CH_W-1:0]   ACT_CH;
  logic              ACT_VALID;
  logic              XFER_START;
  logic [NUM_CH-1:0] SW_REQ_CLR;

  modport slave (
    input  DREQ, DREQ_SENSE_LOW, DACK_SENSE_HIGH, ROT_PRIO, CH_MASK, SW_REQ,
           HLDA, SVC_DONE,
    output HRQ, DACK, ACT_CH, ACT_VALID, XFER_START, SW_REQ_CLR
  );

  modport master (
    output DREQ, DREQ_SENSE_LOW, DACK_SENSE_HIGH, ROT_PRIO, CH_MASK, SW_REQ,
           HLDA, SVC_DONE,
    input  HRQ, DACK, ACT_CH, ACT_VALID, XFER_START, SW_REQ_CLR
  );
endinterface

// File: rtl/dma_priority.sv
// 8237A-style channel request arbiter: synchronizes and qualifies DREQ,
// runs the HRQ/HLDA hold handshake, picks a channel by fixed or rotating
// priority, drives DACK and hands the winner to timing control.
// All outputs come straight from flops; each output register is loaded with
// the value matching the next FSM state so it lines up with the state change.
module dma_priority #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic           CLK,
  input  logic           RESET_N,
  dma_priority_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2,
    REL  = 2'd3
  } state_e;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Priority search. Fixed mode starts at channel 0; rotating mode starts at
  // the pointer and wraps with plain CH_W-bit arithmetic.
  function automatic logic [CH_W-1:0] pick_winner(
    input logic [NUM_CH-1:0] p,
    input logic              rot,
    input logic [CH_W-1:0]   base
  );
    logic [CH_W-1:0] start;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] win;
    logic            found;
    start = rot ? base : '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = start + CH_W'(i);
      if (!found && p[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] req_hw;
  logic [NUM_CH-1:0] pend;
  logic [CH_W-1:0]   winner;

  state_e            state_q,   state_d;
  logic [CH_W-1:0]   ptr_q,     ptr_d;
  logic [CH_W-1:0]   act_ch_q,  act_ch_d;
  logic              hrq_q,     hrq_d;
  logic              vld_q,     vld_d;
  logic              xfer_q,    xfer_d;
  logic [NUM_CH-1:0] sw_clr_q,  sw_clr_d;
  logic [NUM_CH-1:0] dack_q,    dack_d;
  logic [NUM_CH-1:0] dack_act;

  // Two-flop synchronizer for the asynchronous DREQ lines.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.DREQ;
      sync2_q <= sync1_q;
    end
  end

  // Polarity is applied after synchronization; software requests bypass
  // both the synchronizer and the mask.
  assign req_hw = sync2_q ^ {NUM_CH{bus.DREQ_SENSE_LOW}};
  assign pend   = (req_hw & ~bus.CH_MASK) | bus.SW_REQ;
  assign winner = pick_winner(pend, bus.ROT_PRIO, ptr_q);

  // Next-state and next-output logic for the hold/service FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    act_ch_d = act_ch_q;
    sw_clr_d = '0;
    xfer_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend) state_d = REQ;
      end
      REQ: begin
        if (pend == '0) begin
          state_d = IDLE;
        end else if (bus.HLDA) begin
          state_d  = SVC;
          act_ch_d = winner;
          xfer_d   = 1'b1;
        end
      end
      SVC: begin
        // Completion wins over a simultaneous bus revoke.
        if (bus.SVC_DONE) begin
          state_d  = REL;
          sw_clr_d = ch_onehot(act_ch_q) & bus.SW_REQ;
          if (bus.ROT_PRIO) ptr_d = act_ch_q + CH_W'(1);
        end else if (!bus.HLDA) begin
          state_d = REL;
        end
      end
      REL: begin
        if (!bus.HLDA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    hrq_d    = (state_d == REQ) || (state_d == SVC);
    vld_d    = (state_d == SVC);
    dack_act = vld_d ? ch_onehot(act_ch_d) : '0;
    dack_d   = bus.DACK_SENSE_HIGH ? dack_act : ~dack_act;
  end

  // State and registered outputs; DACK reset level follows the current
  // DACK polarity so the line is inactive from the first cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      act_ch_q <= '0;
      hrq_q    <= 1'b0;
      vld_q    <= 1'b0;
      xfer_q   <= 1'b0;
      sw_clr_q <= '0;
      dack_q   <= {NUM_CH{~bus.DACK_SENSE_HIGH}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      act_ch_q <= act_ch_d;
      hrq_q    <= hrq_d;
      vld_q    <= vld_d;
      xfer_q   <= xfer_d;
      sw_clr_q <= sw_clr_d;
      dack_q   <= dack_d;
    end
  end

  assign bus.HRQ        = hrq_q;
  assign bus.DACK       = dack_q;
  assign bus.ACT_CH     = act_ch_q;
  assign bus.ACT_VALID  = vld_q;
  assign bus.XFER_START = xfer_q;
  assign bus.SW_REQ_CLR = sw_clr_q;

endmodule
